// File: rtl/smac_pkg.sv
// Shared definitions for the AC1 result path.
//   ac_width(m)  : bit width needed to hold an accumulator sum of 0..m.
//   row_state_t  : row-tracking states of the AC1 reader.
//   ac1_entry_t  : buffered result layout {data, last} for the default M=16.
package smac_pkg;

    function automatic int ac_width(input int m);
        return $clog2(m) + 1;
    endfunction

    typedef enum logic {
        ROW_MID = 1'b0,
        ROW_END = 1'b1
    } row_state_t;

    // The reader declares the same layout with its own AW, so that a
    // non-default M still works; this one matches the default build.
    typedef struct packed {
        logic [ac_width(16)-1:0] data;
        logic                    last;
    } ac1_entry_t;

endpackage

// File: rtl/ac1_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits, wrap-around pointers.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write wdata at the tail (caller guarantees space or a same-cycle pop)
//   pop        : drop the head (caller guarantees non-empty)
//   rdata      : head entry, always read straight from storage
//   full/empty : occupancy flags, derived from the registered count
module ac1_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;

    // Storage is not reset: its content is only observed while count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ac1_reader.sv
// Reader end of the AC1 result path.
// Captures each final AC1 sum on acc_done, clears AC1 with a registered
// acc_clr pulse, buffers results in a FIFO, tags the last result of each
// row and streams results downstream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   acc_in, acc_done    : final AC1 sum and its one-cycle qualifier
//   acc_clr             : one-cycle pulse in the cycle after a captured sum
//   acc_stall           : buffer full, AC1 controller must hold
//   out_data/out_last   : head result and its end-of-row tag
//   out_valid/out_ready : downstream handshake
//   ovf_err             : sticky, a sum arrived with no room and was dropped
//
// Handshake: a result transfers on any rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0, out_data and
// out_last hold. out_valid never depends on out_ready.
module ac1_reader
    import smac_pkg::*;
#(
    parameter int M     = 16,
    parameter int DEPTH = 4,
    parameter int N_ROW = 8,
    parameter int AW    = ac_width(M)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] acc_in,
    input  logic          acc_done,
    output logic          acc_clr,
    output logic          acc_stall,
    output logic [AW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          ovf_err
);

    localparam int            RW       = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam logic [RW-1:0] LAST_POS = RW'(N_ROW - 1);
    localparam row_state_t    ROW_INIT = (N_ROW == 1) ? ROW_END : ROW_MID;

    typedef struct packed {
        logic [AW-1:0] data;
        logic          last;
    } entry_t;

    entry_t     wr_entry;
    entry_t     rd_entry;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       drop;
    logic [RW-1:0] row_cnt;
    row_state_t    row_state;

    // A full buffer still accepts a sum when the head leaves in the same cycle.
    assign pop  = !fifo_empty && out_ready;
    assign push = acc_done && (!fifo_full || pop);
    assign drop = acc_done && fifo_full && !pop;

    assign wr_entry.data = acc_in;
    assign wr_entry.last = (row_state == ROW_END);

    ac1_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Row tracking, clear pulse and overflow flag. Dropped sums leave the
    // row position untouched and raise no acc_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            row_state <= ROW_INIT;
            acc_clr   <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            acc_clr <= push;
            if (drop) begin
                ovf_err <= 1'b1;
            end
            if (push) begin
                if (row_state == ROW_END) begin
                    row_cnt   <= '0;
                    row_state <= ROW_INIT;
                end else begin
                    row_cnt   <= row_cnt + 1'b1;
                    row_state <= (RW'(row_cnt + 1'b1) == LAST_POS) ? ROW_END : ROW_MID;
                end
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign acc_stall = fifo_full;
    assign out_data  = rd_entry.data;
    assign out_last  = rd_entry.last;

endmodule

// File: tb/tb_ac1_reader.sv
module tb_ac1_reader;

  localparam int M     = 16;
  localparam int DEPTH = 4;
  localparam int N_ROW = 8;
  localparam int AW    = $clog2(M) + 1;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] acc_in;
  logic          acc_done;
  logic          acc_clr;
  logic          acc_stall;
  logic [AW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          ovf_err;

  int n_tests;
  int n_fail;

  // Reference model: buffered results as {data, last}, row position,
  // last-cycle push flag and sticky overflow.
  logic [AW:0] exp_q[$];
  int          m_row;
  logic        m_clr;
  logic        m_ovf;

  ac1_reader #(
    .M     (M),
    .DEPTH (DEPTH),
    .N_ROW (N_ROW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_in    (acc_in),
    .acc_done  (acc_done),
    .acc_clr   (acc_clr),
    .acc_stall (acc_stall),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .ovf_err   (ovf_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_row = 0;
    m_clr = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
    check({tag, "_stall"}, 32'(acc_stall), 32'(exp_q.size() == DEPTH));
    check({tag, "_clr"},   32'(acc_clr),   32'(m_clr));
    check({tag, "_ovf"},   32'(ovf_err),   32'(m_ovf));
    if (exp_q.size() > 0) begin
      check({tag, "_data"}, 32'(out_data), 32'(exp_q[0][AW:1]));
      check({tag, "_last"}, 32'(out_last), 32'(exp_q[0][0]));
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    acc_done  = 1'b0;
    acc_in    = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic cycle(input string tag, input logic done, input logic [AW-1:0] val,
                       input logic rdy);
    logic m_pop;
    logic m_push;
    logic m_drop;
    acc_done  = done;
    acc_in    = val;
    out_ready = rdy;
    m_pop  = (exp_q.size() > 0) && rdy;
    m_push = done && ((exp_q.size() < DEPTH) || m_pop);
    m_drop = done && !m_push;
    @(posedge clk);
    #1;
    if (m_pop) void'(exp_q.pop_front());
    if (m_push) begin
      exp_q.push_back({val, (m_row == N_ROW - 1)});
      m_row = (m_row + 1) % N_ROW;
    end
    if (m_drop) m_ovf = 1'b1;
    m_clr = m_push;
    check_outputs(tag);
    acc_done = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    acc_done = 1'b0;
    acc_in   = '0;
    out_ready = 1'b0;
    rst_n    = 1'b1;
    #2;
    do_reset();

    // single result
    cycle("single_push", 1'b1, AW'(7), 1'b1);
    check("single_data7", 32'(out_data), 32'd7);
    check("single_clr1", 32'(acc_clr), 32'd1);
    cycle("single_pop", 1'b0, '0, 1'b1);
    check("single_clr0", 32'(acc_clr), 32'd0);
    check("single_empty", 32'(out_valid), 32'd0);

    // row tagging: 1..8 then 9
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cycle("row_push", 1'b1, AW'(i), 1'b1);
      check("row_last", 32'(out_last), 32'(i == 8));
    end
    cycle("row_drain", 1'b0, '0, 1'b1);

    // fill, stall, drop, drain
    do_reset();
    for (int i = 3; i <= 6; i++) cycle("fill", 1'b1, AW'(i), 1'b0);
    check("fill_stall", 32'(acc_stall), 32'd1);
    check("fill_head", 32'(out_data), 32'd3);
    cycle("drop", 1'b1, AW'(9), 1'b0);
    check("drop_ovf", 32'(ovf_err), 32'd1);
    check("drop_noclr", 32'(acc_clr), 32'd0);
    for (int i = 0; i < 5; i++) cycle("drop_drain", 1'b0, '0, 1'b1);

    // simultaneous push and pop at full
    do_reset();
    for (int i = 3; i <= 6; i++) cycle("fill2", 1'b1, AW'(i), 1'b0);
    cycle("simul", 1'b1, AW'(10), 1'b1);
    check("simul_stall", 32'(acc_stall), 32'd1);
    check("simul_ovf", 32'(ovf_err), 32'd0);
    check("simul_head", 32'(out_data), 32'd4);
    for (int i = 0; i < 5; i++) cycle("simul_drain", 1'b0, '0, 1'b1);

    // asynchronous reset mid-stream
    do_reset();
    cycle("mid_a", 1'b1, AW'(11), 1'b0);
    cycle("mid_b", 1'b1, AW'(12), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("areset_valid", 32'(out_valid), 32'd0);
    check("areset_stall", 32'(acc_stall), 32'd0);
    check("areset_ovf", 32'(ovf_err), 32'd0);
    check("areset_clr", 32'(acc_clr), 32'd0);
    #2;
    rst_n = 1'b1;
    cycle("after_reset", 1'b1, AW'(13), 1'b0);
    cycle("after_reset_hold", 1'b0, '0, 1'b1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), AW'($urandom_range(0, M)),
            1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ac1_reader.md
Name: ac1_reader

Overview:
- Reader end of the first accumulator (AC1) result path.
- Captures each final AC1 sum when the accumulation window closes, clears AC1 through a pulse, and buffers results in a small FIFO.
- Streams results to the next datapath stage over valid/ready and tags the last result of each row.
- Applies backpressure to the AC1 controller when the buffer is full.

Parameters:
M, 16, AC1 accumulation length; data width AW = $clog2(M)+1 (AW = 5 at default).
DEPTH, 4, FIFO entries; power of two, ≥2.
N_ROW, 8, results per row; out_last marks result N_ROW-1 of each row.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
acc_in  in  AW  final AC1 sum, valid only in the cycle acc_done=1.
acc_done  in  1  one-cycle pulse: acc_in is final.
acc_clr  out  1  one-cycle pulse clearing the AC1 register; registered.
acc_stall  out  1  FIFO full; AC1 controller must hold and not raise acc_done.
out_data  out  AW  head-of-FIFO result.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  downstream accepts the result.
out_last  out  1  out_data is the last result of a row.
ovf_err  out  1  sticky: acc_done arrived with no space.

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - pointers 0, count 0, row counter 0, ovf_err 0, acc_clr 0.
  - Resulting outputs: out_valid 0, acc_stall 0.
  - out_data and out_last read entry 0, which is don't-care while out_valid=0.
  - Reset mid-stream discards buffered data; no acc_clr is issued.
- Push: push = acc_done & (count<DEPTH | pop).
  - Writes {acc_in, tag} at wptr; wptr wraps modulo DEPTH.
  - tag = (row_cnt==N_ROW-1).
  - row_cnt increments on each push and wraps to 0 after N_ROW-1.
  - acc_clr=1 in the cycle after a push only.
- Pop: pop = out_valid & out_ready. rptr advances modulo DEPTH.
- Count: push & !pop increments; pop & !push decrements; both leaves it unchanged.
  - When full, simultaneous push and pop is accepted.
- acc_stall = (count==DEPTH), registered-state derived only; no combinational path from out_ready.
- Drop: acc_done & count==DEPTH & !pop.
  - The value is dropped: no write, no acc_clr, row_cnt unchanged.
  - ovf_err is set and stays set until reset.
- Latency: acc_done at cycle t gives out_valid=1 at t+1 when the FIFO was empty. No bypass; out_data is always FIFO storage.
- Outputs are stable while out_valid & !out_ready: out_data and out_last hold.
- Arithmetic and widths:
  - AW bits are kept unchanged; no extension or saturation.
  - The maximum sum is M, which fits in AW.
  - row_cnt width is $clog2(N_ROW); N_ROW=1 means every result is last.
- State machine: row tracking only.
  - States ROW_MID and ROW_END.
  - ROW_END when row_cnt==N_ROW-1.
  - A push in ROW_END returns to ROW_MID with row_cnt=0.

Decomposition:
- Package smac_pkg holds:
  - function ac_width(M) returning $clog2(M)+1.
  - typedef of the FIFO entry struct {data, last}.
- One natural sub-module, ac1_fifo: generic DEPTH×width synchronous FIFO with wrap pointers, count, full and empty.
- ac1_reader adds the tag, row counter, acc_clr register, drop logic and ovf_err.

Test Plan:
- Single result: reset, out_ready=1, acc_done with acc_in=7 at t0. Required: out_valid=1 and out_data=7 at t0+1; acc_clr pulse at t0+1 only; out_valid=0 at t0+2.
- Row tagging: 8 pushes of values 1..8 with out_ready=1. Required: out_last=1 only with data 8. A 9th push of value 9 gives out_last=0.
- Fill and stall: out_ready=0, pushes of 3,4,5,6. Required: acc_stall=1 after the 4th; out_data holds at 3.
- Drop: while full, push value 9. Required: ovf_err=1, no acc_clr. Then out_ready=1 drains 3,4,5,6 in order, and 9 never appears.
- Simultaneous at full: full with out_ready=1 and acc_done (value 10) in the same cycle. Required: pop of 3, 10 accepted, acc_stall stays 1, ovf_err stays 0. Drain order is 4,5,6,10.
- Reset mid-stream: 2 entries buffered, then rst_n=0 asynchronously between edges. Required: out_valid=0, acc_stall=0 and ovf_err=0 immediately. After release, the next push is tagged as row position 0.
